// File: rtl/buscaminas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buscaminas_pkg
// Description : Shared types and constants for the Buscaminas board logic:
//               board-size defaults, reveal FSM states, the neighbour offset
//               table walked by the reveal engine, and the visible-board code
//               written for a mined cell.
// Revision    : 1.0 - initial release
// ============================================================================
package buscaminas_pkg;

    localparam int N_DEFAULT       = 8;
    localparam int COORD_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Last scan index: k=0 is the centre cell, k=1..8 the neighbours.
    localparam logic [3:0] K_LAST = 4'd8;

    // Neighbour offsets, 2-bit two's complement, entry j (for k=j+1) at bits
    // [2j+1:2j]. Order: (-1,-1) (0,-1) (1,-1) (-1,0) (1,0) (-1,1) (0,1) (1,1).
    localparam logic [15:0] OFF_DX = {2'b01, 2'b00, 2'b11, 2'b01,
                                      2'b11, 2'b01, 2'b00, 2'b11};
    localparam logic [15:0] OFF_DY = {2'b01, 2'b01, 2'b01, 2'b00,
                                      2'b00, 2'b11, 2'b11, 2'b11};

    localparam logic [3:0] MINE_CODE = 4'hF;

    function automatic logic signed [1:0] off_dx(input logic [2:0] j);
        return $signed(OFF_DX[{j, 1'b0} +: 2]);
    endfunction

    function automatic logic signed [1:0] off_dy(input logic [2:0] j);
        return $signed(OFF_DY[{j, 1'b0} +: 2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/revelar_casilla_vecino_addr.sv
`default_nettype none
// ============================================================================
// Module      : vecino_addr
// Description : Combinational neighbour address generator. Given a cell and a
//               scan index k, returns the mine-map address to read and whether
//               that neighbour lies on the board. k=0 (and any out-of-range
//               neighbour) yields the centre cell itself.
// Ports       : cx, cy     - centre cell coordinates
//               k          - scan index 0..8
//               rd_x, rd_y - read address
//               in_range   - neighbour is on the board (always 1 for k=0)
// Revision    : 1.0 - initial release
// ============================================================================
module vecino_addr
    import buscaminas_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic [3:0]         k,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               in_range
);

    localparam logic [COORD_W:0] N_W = (COORD_W + 1)'(N);

    logic [2:0]                j;
    logic signed [1:0]         dx;
    logic signed [1:0]         dy;
    logic signed [COORD_W:0]   nx;
    logic signed [COORD_W:0]   ny;

    always_comb begin
        // k=1..8 maps to table entry 0..7; k=8 wraps to 7 through the 3-bit subtract.
        j  = k[2:0] - 3'd1;
        dx = off_dx(j);
        dy = off_dy(j);
        nx = $signed({1'b0, cx}) + $signed({{(COORD_W - 1){dx[1]}}, dx});
        ny = $signed({1'b0, cy}) + $signed({{(COORD_W - 1){dy[1]}}, dy});

        rd_x     = cx;
        rd_y     = cy;
        in_range = 1'b1;
        if (k != 4'd0) begin
            // A negative result has its sign bit set, so as unsigned it is
            // always >= N; one compare covers both edges of the board.
            in_range = (k <= K_LAST) && ($unsigned(nx) < N_W) && ($unsigned(ny) < N_W);
            if (in_range) begin
                rd_x = nx[COORD_W-1:0];
                rd_y = ny[COORD_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/revelar_casilla.sv
`default_nettype none
// ============================================================================
// Module      : revelar_casilla
// Description : Reveal engine. Reads the mine map for a selected cell and its
//               eight neighbours (one read per cycle, 1-cycle read latency),
//               reports mine/adjacent-count and writes the visible board.
// Ports       : clk, rst                - clock, sync active-high reset
//               start, casilla_x/y      - reveal request (taken when ready)
//               ready                   - engine idle
//               mine_rd_x/y, mine_rd_data - mine-map read port
//               done                    - one-cycle result pulse
//               is_mine, vecinos        - result
//               wr_en, wr_x/y, wr_data  - visible-board write
// Revision    : 1.0 - initial release
// ============================================================================
module revelar_casilla
    import buscaminas_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] casilla_x,
    input  logic [COORD_W-1:0] casilla_y,
    output logic               ready,
    output logic [COORD_W-1:0] mine_rd_x,
    output logic [COORD_W-1:0] mine_rd_y,
    input  logic               mine_rd_data,
    output logic               done,
    output logic               is_mine,
    output logic [3:0]         vecinos,
    output logic               wr_en,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [3:0]         wr_data
);

    localparam logic [COORD_W:0] N_W = (COORD_W + 1)'(N);

    state_t             state_q,  state_d;
    logic [3:0]         k_q,      k_d;
    logic [COORD_W-1:0] cx_q,     cx_d;
    logic [COORD_W-1:0] cy_q,     cy_d;
    // Tags for the read in flight: its data comes back the following cycle.
    logic               pend_valid_q,  pend_valid_d;
    logic               pend_centre_q, pend_centre_d;
    logic               pend_count_q,  pend_count_d;
    logic               is_mine_q, is_mine_d;
    logic [3:0]         vecinos_q, vecinos_d;
    logic               done_q,    done_d;
    logic [3:0]         wr_data_q, wr_data_d;

    logic [3:0]         addr_k;
    logic               nb_in_range;
    logic               req_ok;

    // Outside SCAN the index is forced to 0 so the read address rests on the centre.
    assign addr_k = (state_q == ST_SCAN) ? k_q : 4'd0;

    vecino_addr #(
        .N       (N),
        .COORD_W (COORD_W)
    ) u_vecino_addr (
        .cx       (cx_q),
        .cy       (cy_q),
        .k        (addr_k),
        .rd_x     (mine_rd_x),
        .rd_y     (mine_rd_y),
        .in_range (nb_in_range)
    );

    assign req_ok = start && ({1'b0, casilla_x} < N_W) && ({1'b0, casilla_y} < N_W);

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        pend_valid_d  = 1'b0;
        pend_centre_d = 1'b0;
        pend_count_d  = 1'b0;
        is_mine_d     = is_mine_q;
        vecinos_d     = vecinos_q;
        done_d        = 1'b0;
        wr_data_d     = wr_data_q;

        if (pend_valid_q && mine_rd_data) begin
            if (pend_centre_q) is_mine_d = 1'b1;
            if (pend_count_q)  vecinos_d = vecinos_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    state_d   = ST_SCAN;
                    k_d       = 4'd0;
                    cx_d      = casilla_x;
                    cy_d      = casilla_y;
                    is_mine_d = 1'b0;
                    vecinos_d = 4'd0;
                end
            end
            ST_SCAN: begin
                pend_valid_d  = 1'b1;
                pend_centre_d = (k_q == 4'd0);
                pend_count_d  = (k_q != 4'd0) && nb_in_range;
                if (k_q == K_LAST) state_d = ST_DRAIN;
                else               k_d     = k_q + 4'd1;
            end
            ST_DRAIN: begin
                // The last read lands this cycle; use the updated totals.
                state_d   = ST_DONE;
                done_d    = 1'b1;
                wr_data_d = is_mine_d ? MINE_CODE : vecinos_d;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            k_q           <= 4'd0;
            cx_q          <= '0;
            cy_q          <= '0;
            pend_valid_q  <= 1'b0;
            pend_centre_q <= 1'b0;
            pend_count_q  <= 1'b0;
            is_mine_q     <= 1'b0;
            vecinos_q     <= 4'd0;
            done_q        <= 1'b0;
            wr_data_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            pend_valid_q  <= pend_valid_d;
            pend_centre_q <= pend_centre_d;
            pend_count_q  <= pend_count_d;
            is_mine_q     <= is_mine_d;
            vecinos_q     <= vecinos_d;
            done_q        <= done_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = done_q;
    assign wr_en   = done_q;
    assign is_mine = is_mine_q;
    assign vecinos = vecinos_q;
    assign wr_x    = cx_q;
    assign wr_y    = cy_q;
    assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: doc/revelar_casilla.md
# revelar_casilla

Reveal engine for the Buscaminas board. It accepts a selected cell coordinate, the same `casilla_x`/`casilla_y` pair the cursor-movement logic produces, and reads the mine map for that cell and its eight neighbours, one read per cycle. It reports whether the cell is a mine and how many adjacent mines it has, then writes the result into the visible-board store.

## Interface
Parameters:
- `N`, 8: board side length in cells.
- `COORD_W`, 3: coordinate width; must satisfy 2^COORD_W ≥ N.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  reveal request; accepted only when `ready`=1.
- `casilla_x`  in  COORD_W  column of the cell to reveal.
- `casilla_y`  in  COORD_W  row of the cell to reveal.
- `ready`  out  1  high only in IDLE.
- `mine_rd_x`  out  COORD_W  mine-map read column.
- `mine_rd_y`  out  COORD_W  mine-map read row.
- `mine_rd_data`  in  1  mine bit for the address issued the previous cycle (1-cycle read latency).
- `done`  out  1  one-cycle pulse; results valid.
- `is_mine`  out  1  revealed cell holds a mine.
- `vecinos`  out  4  adjacent-mine count, 0..8.
- `wr_en`  out  1  visible-board write strobe, coincident with `done`.
- `wr_x`, `wr_y`  out  COORD_W  write address, equal to the latched cell.
- `wr_data`  out  4  `4'hF` if `is_mine`, else `vecinos`.

## Operation
States and transitions:
- IDLE → SCAN when `start`=1 and both coordinates are < N.
  - The coordinates are latched at that edge.
  - If either coordinate is ≥ N, the request is ignored and the block stays in IDLE.
- SCAN runs for 9 cycles with index k = 0..8.
  - k=0 reads the centre cell.
  - k=1..8 read the neighbours at offsets (dx,dy) in this order: (-1,-1), (0,-1), (1,-1), (-1,0), (1,0), (-1,1), (0,1), (1,1).
  - SCAN → DRAIN after k=8.
- DRAIN lasts 1 cycle and accumulates the last read.
- DONE lasts 1 cycle: `done`=`wr_en`=1. DONE → IDLE.

Read and accumulate rules:
- Neighbour coordinates are computed at COORD_W+1 bits, signed.
- An out-of-range neighbour (coordinate < 0 or ≥ N) issues no new address; the read address holds at the centre cell. Its returned data is masked and does not count. There is no wrap-around: x=0, dx=-1 never reads column N-1.
- The accumulator is cleared on start acceptance.
- When returned data has k=0, it sets `is_mine`. When it has k≥1 and is in range, it increments `vecinos` by 1. The maximum is 8, so there is no overflow.
- A mine at the centre cell does not suppress the neighbour count; `vecinos` is always computed.

Output behaviour:
- `is_mine`, `vecinos`, `wr_*` hold their values from DONE until the next start is accepted.
- `start` while `ready`=0 is ignored and not queued.

Reset values: state IDLE, `ready`=1, `done`=0, `wr_en`=0, `is_mine`=0, `vecinos`=0, `wr_x`=`wr_y`=0, `wr_data`=0, `mine_rd_x`=`mine_rd_y`=0.
- Reset asserted mid-operation aborts on the next edge.
- An aborted reveal produces no `done` or `wr_en` pulse.

## Timing
- Cycle T: `start` is sampled with `ready`=1.
- T+1..T+9: SCAN. The address for index k is driven in cycle T+1+k, and its data is sampled in T+2+k.
- T+10: DRAIN.
- T+11: DONE, with `done`=`wr_en`=1 for exactly one cycle.
- T+12: IDLE, `ready`=1. A new `start` may be accepted in that same cycle, since `ready` is combinational from state.
- Latency from start to `done` is a fixed 11 cycles regardless of board position. Throughput is one reveal per 12 cycles.
- `mine_rd_x`/`mine_rd_y` are combinational from the state, index and latched coordinates. They hold the centre address in IDLE, DRAIN and DONE.

## Structure
- Package `buscaminas_pkg` holds:
  - `N` and `COORD_W` defaults;
  - the state enum (IDLE, SCAN, DRAIN, DONE);
  - the 8-entry neighbour offset table as a constant;
  - `MINE_CODE` = `4'hF`.
- One combinational sub-module, `vecino_addr`. It takes the latched cell and index k, and returns the read address plus an in-range flag. It is reusable by a later flood-fill block.

## Test plan
- Interior cell (3,3), mines at (2,2), (4,4) and (3,3) → `done` at T+11; `is_mine`=1, `vecinos`=2, `wr_data`=`4'hF`, `wr_x`=3, `wr_y`=3.
- Corner cell (0,0), mines at (7,7), (0,7), (7,0) and (1,1) → `vecinos`=1, `is_mine`=0. No read address ever reaches column 7 or row 7.
- Corner cell (7,7) with all other 63 cells mined → `vecinos`=3, `wr_data`=3. Cell (4,4) with the whole board mined → `vecinos`=8.
- `start` pulsed at T+5 during a reveal → ignored, exactly one `done`. `start` held high continuously → `done` pulses every 12 cycles.
- `rst` asserted at T+6 → next cycle IDLE, `ready`=1, `vecinos`=0, and no `done` or `wr_en` pulse afterward.
- With N=6, request at (6,2) → ignored, `ready` stays 1, no reads and no `done`.
